board_row_reader: RTL and testbench



---
 rtl/board_row_reader.sv | 161 ++++++++++++++++
 tb/tb_board_row_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_row_reader.sv
// rtl/board_row_reader.sv - fetches one guess row (pins + yellow/green hints) from the board RAM
// Pins stream out one per beat as read data returns; hint counts and WIN are latched at completion.
module board_row_reader #(
  parameter int MAX_PINS     = 20,
  parameter int MAX_ROWS     = 100,
  parameter int PIN_POS_W    = 5,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int HINTS_OFFSET = 2048,
  parameter int RD_LAT       = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REQ,
  input  logic [7:0]           ROW,
  input  logic [PIN_POS_W-1:0] PINS_COUNT,
  output logic [ADDR_W-1:0]    RAM_RADDR,
  input  logic [DATA_W-1:0]    RAM_Q,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ROW_ERR,
  output logic                 PIN_VALID,
  output logic [PIN_POS_W-1:0] PIN_INDEX,
  output logic [DATA_W-1:0]    PIN_COLOR,
  output logic [DATA_W-1:0]    YELLOW,
  output logic [DATA_W-1:0]    GREEN,
  output logic                 WIN
);

  localparam int AW    = ADDR_W + 8;
  localparam int TAG_W = PIN_POS_W + 3;
  localparam logic [1:0] K_PIN = 2'd0;
  localparam logic [1:0] K_YEL = 2'd1;
  localparam logic [1:0] K_GRN = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t               state_q;
  logic [7:0]           row_q;
  logic [PIN_POS_W-1:0] n_q;
  logic [PIN_POS_W:0]   idx_q;
  logic [DATA_W-1:0]    yel_hold_q;
  // chain_q[0] tags the address on RAM_RADDR; chain_q[RD_LAT] tags the word on RAM_Q.
  logic [TAG_W-1:0]     chain_q [RD_LAT+1];

  logic [ADDR_W-1:0]    issue_addr_d;
  logic [TAG_W-1:0]     issue_tag_d;
  logic                 issue_last_d;
  logic                 tail_valid;
  logic [1:0]           tail_kind;
  logic                 grn_arriving;

  function automatic logic [PIN_POS_W-1:0] clamp_n(input logic [PIN_POS_W-1:0] c);
    if (c < PIN_POS_W'(2)) return PIN_POS_W'(2);
    if (c > PIN_POS_W'(MAX_PINS)) return PIN_POS_W'(MAX_PINS);
    return c;
  endfunction

  function automatic logic [ADDR_W-1:0] pin_addr(input logic [7:0] r, input logic [PIN_POS_W:0] i);
    logic [AW-1:0] a;
    a = AW'(r) * AW'(MAX_PINS) + AW'(i);
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] hint_addr(input logic [7:0] r, input logic sel_grn);
    logic [AW-1:0] a;
    a = AW'(HINTS_OFFSET) + (AW'(r) << 1) + AW'(sel_grn);
    return a[ADDR_W-1:0];
  endfunction

  always_comb begin
    issue_addr_d = hint_addr(row_q, 1'b1);
    issue_tag_d  = {1'b1, K_GRN, {PIN_POS_W{1'b0}}};
    issue_last_d = 1'b1;
    if (idx_q < {1'b0, n_q}) begin
      issue_addr_d = pin_addr(row_q, idx_q);
      issue_tag_d  = {1'b1, K_PIN, idx_q[PIN_POS_W-1:0]};
      issue_last_d = 1'b0;
    end else if (idx_q == {1'b0, n_q}) begin
      issue_addr_d = hint_addr(row_q, 1'b0);
      issue_tag_d  = {1'b1, K_YEL, {PIN_POS_W{1'b0}}};
      issue_last_d = 1'b0;
    end
  end

  assign tail_valid   = chain_q[RD_LAT][TAG_W-1];
  assign tail_kind    = chain_q[RD_LAT][TAG_W-2 -: 2];
  assign PIN_VALID    = tail_valid && (tail_kind == K_PIN);
  assign PIN_INDEX    = PIN_VALID ? chain_q[RD_LAT][PIN_POS_W-1:0] : '0;
  assign PIN_COLOR    = PIN_VALID ? RAM_Q : '0;
  // Green reaches RAM_Q next cycle: that cycle is FINISH, and its edge captures green directly.
  assign grn_arriving = chain_q[RD_LAT-1][TAG_W-1] && (chain_q[RD_LAT-1][TAG_W-2 -: 2] == K_GRN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      row_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      yel_hold_q <= '0;
      for (int j = 0; j <= RD_LAT; j++) chain_q[j] <= '0;
      RAM_RADDR  <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ROW_ERR    <= 1'b0;
      YELLOW     <= '0;
      GREEN      <= '0;
      WIN        <= 1'b0;
    end else begin
      for (int j = 1; j <= RD_LAT; j++) chain_q[j] <= chain_q[j-1];
      chain_q[0] <= '0;
      DONE       <= 1'b0;
      if (tail_valid && (tail_kind == K_YEL)) yel_hold_q <= RAM_Q;

      case (state_q)
        IDLE: begin
          if (REQ) begin
            row_q <= ROW;
            n_q   <= clamp_n(PINS_COUNT);
            BUSY  <= 1'b1;
            if (int'(ROW) >= MAX_ROWS) begin
              ROW_ERR <= 1'b1;
              state_q <= FINISH;
            end else begin
              ROW_ERR    <= 1'b0;
              RAM_RADDR  <= pin_addr(ROW, '0);
              chain_q[0] <= {1'b1, K_PIN, {PIN_POS_W{1'b0}}};
              idx_q      <= (PIN_POS_W+1)'(1);
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          RAM_RADDR  <= issue_addr_d;
          chain_q[0] <= issue_tag_d;
          idx_q      <= idx_q + 1'b1;
          if (issue_last_d) state_q <= DRAIN;
        end
        DRAIN: begin
          if (grn_arriving) state_q <= FINISH;
        end
        FINISH: begin
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          state_q <= IDLE;
          if (ROW_ERR) begin
            YELLOW <= '0;
            GREEN  <= '0;
            WIN    <= 1'b0;
          end else begin
            YELLOW <= yel_hold_q;
            GREEN  <= RAM_Q;
            WIN    <= (RAM_Q == DATA_W'(n_q));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_row_reader.sv
// tb/tb_board_row_reader.sv - directed bench for board_row_reader at RD_LAT 1 and 2
// Two instances share one RAM image; each has its own read-latency model.
module tb_board_row_reader;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int PW = 5;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          REQ1 = 1'b0, REQ2 = 1'b0;
  logic [7:0]    ROW1 = '0, ROW2 = '0;
  logic [PW-1:0] PC1 = '0, PC2 = '0;
  logic [AW-1:0] RA1, RA2;
  logic [DW-1:0] Q1 = '0, Q2 = '0, Q2a = '0;
  logic          BUSY1, DONE1, ERR1, PV1, WIN1;
  logic          BUSY2, DONE2, ERR2, PV2, WIN2;
  logic [PW-1:0] PI1, PI2;
  logic [DW-1:0] PCOL1, Y1, G1, PCOL2, Y2, G2;

  logic [DW-1:0] mem [4096];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [PW-1:0] b_idx [$];
  logic [DW-1:0] b_col [$];
  int            b_cyc [$];
  int            a_q [$];
  int            done1_n = 0, done1_cyc = 0;
  logic          done1_busy = 1'b0;
  logic [DW-1:0] b2_col [$];
  int            b2_cyc [$];
  int            done2_n = 0, done2_cyc = 0;

  board_row_reader #(.RD_LAT(1)) u_l1 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ1), .ROW(ROW1), .PINS_COUNT(PC1),
    .RAM_RADDR(RA1), .RAM_Q(Q1), .BUSY(BUSY1), .DONE(DONE1), .ROW_ERR(ERR1),
    .PIN_VALID(PV1), .PIN_INDEX(PI1), .PIN_COLOR(PCOL1),
    .YELLOW(Y1), .GREEN(G1), .WIN(WIN1));

  board_row_reader #(.RD_LAT(2)) u_l2 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ2), .ROW(ROW2), .PINS_COUNT(PC2),
    .RAM_RADDR(RA2), .RAM_Q(Q2), .BUSY(BUSY2), .DONE(DONE2), .ROW_ERR(ERR2),
    .PIN_VALID(PV2), .PIN_INDEX(PI2), .PIN_COLOR(PCOL2),
    .YELLOW(Y2), .GREEN(G2), .WIN(WIN2));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) begin
    Q1  <= mem[RA1];
    Q2a <= mem[RA2];
    Q2  <= Q2a;
  end

  always @(negedge CLK) begin
    if (PV1) begin
      b_idx.push_back(PI1);
      b_col.push_back(PCOL1);
      b_cyc.push_back(cyc);
    end
    if (BUSY1) a_q.push_back(int'(RA1));
    if (DONE1) begin
      done1_n    = done1_n + 1;
      done1_cyc  = cyc;
      done1_busy = BUSY1;
    end
    if (PV2) begin
      b2_col.push_back(PCOL2);
      b2_cyc.push_back(cyc);
    end
    if (DONE2) begin
      done2_n   = done2_n + 1;
      done2_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req1(input logic [7:0] row, input logic [PW-1:0] pins, output int acc);
    @(negedge CLK);
    REQ1 = 1'b1; ROW1 = row; PC1 = pins;
    @(posedge CLK); #1;
    acc = cyc;
    REQ1 = 1'b0;
  endtask

  task automatic wait_done1(input int start_n, output int ok);
    int t;
    ok = 0; t = 0;
    while (t < 100 && ok == 0) begin
      @(negedge CLK); #1;
      if (done1_n > start_n) ok = 1;
      t++;
    end
  endtask

  function automatic int beat(input int i);
    return (int'(b_idx[i]) << 16) | (int'(b_col[i]) << 8);
  endfunction

  initial begin
    int acc, acc2, ok, bn, an, dn, dn2, b2n, t;
    int t1_addr [6] = '{60, 61, 62, 63, 2054, 2055};
    int t1_col  [4] = '{1, 4, 2, 5};

    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    mem[60] = 8'd1; mem[61] = 8'd4; mem[62] = 8'd2; mem[63] = 8'd5;
    mem[2054] = 8'd1; mem[2055] = 8'd2;
    for (int i = 0; i < 6; i++) mem[i] = 8'(10 + i);
    mem[2048] = 8'd3; mem[2049] = 8'd6;
    for (int i = 0; i < 20; i++) mem[100 + i] = 8'(8'h20 + i);
    mem[2058] = 8'd7; mem[2059] = 8'd20;
    mem[140] = 8'd9; mem[141] = 8'd8; mem[142] = 8'd7;
    mem[2062] = 8'd0; mem[2063] = 8'd3;

    repeat (2) @(negedge CLK);
    check("reset_outputs", {RA1, BUSY1, DONE1, ERR1, PV1, PI1, PCOL1, Y1, G1, WIN1}, 64'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Single row, RD_LAT 1.
    bn = b_idx.size(); an = a_q.size(); dn = done1_n;
    req1(8'd3, 5'd4, acc);
    wait_done1(dn, ok);
    check("t1_done_seen", ok, 1);
    check("t1_latency", done1_cyc - acc, 7);
    check("t1_busy_in_done", done1_busy, 0);
    for (int i = 0; i < 6; i++) check("t1_addr", a_q[an + i], t1_addr[i]);
    check("t1_beat_count", b_idx.size() - bn, 4);
    for (int i = 0; i < 4; i++)
      check("t1_beat", beat(bn + i) | (b_cyc[bn + i] - acc), (i << 16) | (t1_col[i] << 8) | (i + 1));
    check("t1_hints", {ERR1, Y1, G1, WIN1}, {1'b0, 8'd1, 8'd2, 1'b0});
    @(negedge CLK); #1;
    check("t1_done_one_cycle", DONE1, 0);

    // Win detect, RD_LAT 2.
    dn2 = done2_n; b2n = b2_cyc.size();
    @(negedge CLK);
    REQ2 = 1'b1; ROW2 = 8'd0; PC2 = 5'd6;
    @(posedge CLK); #1;
    acc = cyc; REQ2 = 1'b0;
    t = 0;
    while (t < 100 && done2_n == dn2) begin
      @(negedge CLK); #1;
      t++;
    end
    check("t2_done_seen", done2_n - dn2, 1);
    check("t2_latency", done2_cyc - acc, 10);
    check("t2_beat_count", b2_cyc.size() - b2n, 6);
    check("t2_first_beat_cycle", b2_cyc[b2n] - acc, 2);
    check("t2_colors", {b2_col[b2n], b2_col[b2n + 5]}, {8'd10, 8'd15});
    check("t2_hints", {ERR2, Y2, G2, WIN2}, {1'b0, 8'd3, 8'd6, 1'b1});

    // Clamp low: PINS_COUNT 0 -> 2 pins.
    bn = b_idx.size(); an = a_q.size(); dn = done1_n;
    req1(8'd5, 5'd0, acc);
    wait_done1(dn, ok);
    check("t3a_latency", done1_cyc - acc, 5);
    check("t3a_beat_count", b_idx.size() - bn, 2);
    check("t3a_hint_addrs", {a_q[an + 2], a_q[an + 3]}, {32'd2058, 32'd2059});
    check("t3a_hints", {ERR1, Y1, G1, WIN1}, {1'b0, 8'd7, 8'd20, 1'b0});

    // Clamp high: PINS_COUNT 31 -> 20 pins.
    bn = b_idx.size(); dn = done1_n;
    req1(8'd5, 5'd31, acc);
    wait_done1(dn, ok);
    check("t3b_latency", done1_cyc - acc, 23);
    check("t3b_beat_count", b_idx.size() - bn, 20);
    check("t3b_last_beat", beat(bn + 19) | (b_cyc[bn + 19] - acc), (19 << 16) | (8'h33 << 8) | 20);
    check("t3b_hints", {ERR1, Y1, G1, WIN1}, {1'b0, 8'd7, 8'd20, 1'b1});

    // Out-of-range row.
    bn = b_idx.size(); dn = done1_n;
    req1(8'd100, 5'd4, acc);
    wait_done1(dn, ok);
    check("t3c_latency", done1_cyc - acc, 1);
    check("t3c_beat_count", b_idx.size() - bn, 0);
    check("t3c_err_hints", {ERR1, Y1, G1, WIN1}, {1'b1, 8'd0, 8'd0, 1'b0});
    check("t3c_raddr_held", RA1, 12'd2059);

    // REQ held high through a request, then a back-to-back REQ in the DONE cycle.
    bn = b_idx.size(); dn = done1_n;
    req1(8'd3, 5'd4, acc);
    REQ1 = 1'b1; ROW1 = 8'd9; PC1 = 5'd2;
    wait_done1(dn, ok);
    check("t4_latency1", done1_cyc - acc, 7);
    check("t4_beats1", b_idx.size() - bn, 4);
    check("t4_hints1", {ERR1, Y1, G1, WIN1}, {1'b0, 8'd1, 8'd2, 1'b0});
    ROW1 = 8'd7; PC1 = 5'd3;
    @(posedge CLK); #1;
    acc2 = cyc; REQ1 = 1'b0;
    check("t4_restart", {BUSY1, RA1}, {1'b1, 12'd140});
    dn2 = done1_n;
    wait_done1(dn2, ok);
    check("t4_latency2", done1_cyc - acc2, 6);
    check("t4_done_count", done1_n - dn, 2);
    check("t4_beats_total", b_idx.size() - bn, 7);
    check("t4_colors2", {b_col[bn + 4], b_col[bn + 5], b_col[bn + 6]}, {8'd9, 8'd8, 8'd7});
    check("t4_hints2", {ERR1, Y1, G1, WIN1}, {1'b0, 8'd0, 8'd3, 1'b1});

    // Reset during the third address cycle.
    dn = done1_n;
    req1(8'd3, 5'd4, acc);
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("t5_async_reset", {RA1, BUSY1, DONE1, ERR1, PV1, PI1, PCOL1, Y1, G1, WIN1}, 64'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    check("t5_no_done", done1_n - dn, 0);
    check("t5_idle_after", {BUSY1, PV1, Y1, G1, WIN1}, 64'd0);
    bn = b_idx.size();
    req1(8'd0, 5'd6, acc);
    wait_done1(dn, ok);
    check("t5_latency", done1_cyc - acc, 9);
    check("t5_beat_count", b_idx.size() - bn, 6);
    check("t5_colors", {b_col[bn], b_col[bn + 5]}, {8'd10, 8'd15});
    check("t5_hints", {ERR1, Y1, G1, WIN1}, {1'b0, 8'd3, 8'd6, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
